c9_bist_ctrl: RTL
=================

C9_BIST_CTRL -- requirements
Module: c9_bist_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2, cycles each pattern is held on cut_in before capture; legal range 1..15.
REQ-002 Parameter GOLDEN_SIG, default 16'h1D0F, fault-free signature of the 4-input/1-output circuit under test.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin an exhaustive test run.
REQ-006 abort  input  1  synchronous cancel of a run in progress.
REQ-007 cut_in  output  4  pattern driven to the circuit under test: bit0=G1gat, bit1=G2gat, bit2=G3gat, bit3=G4gat.
REQ-008 cut_out  input  1  circuit-under-test response (G5gat).
REQ-009 busy  output  1  high while in APPLY or CAPTURE.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  in DONE, (signature == GOLDEN_SIG); 0 in all other states.
REQ-012 signature  output  16  current compaction register.
REQ-013 resp_vec  output  16  per-pattern raw response log (see Configuration).

Function
REQ-014 States SHALL be IDLE, APPLY, CAPTURE, DONE; all outputs SHALL be registered or decoded from registered state.
REQ-015 IDLE: start=1 -> APPLY, with pattern counter=0, settle counter=0, signature=16'h0000, resp_vec=0.
REQ-016 APPLY: cut_in = pattern counter; after SETTLE_CYC cycles in APPLY -> CAPTURE.
REQ-017 CAPTURE (one cycle): sample cut_out; fb = signature[15] XOR cut_out; signature <= {signature[14:0],1'b0} XOR (fb ? 16'h1021 : 16'h0000).
REQ-018 CAPTURE: pattern counter < 15 -> increment it, go to APPLY; pattern counter = 15 -> go to DONE.
REQ-019 Patterns SHALL be applied in ascending order 0..15, each exactly once; the pattern counter does not wrap within a run.
REQ-020 Per-pattern cost SHALL be SETTLE_CYC+1 cycles; done SHALL rise on the 16*(SETTLE_CYC+1)-th rising edge after the edge that samples start.
REQ-021 DONE: done, pass and signature held stable; cut_in = 4'h0; start=1 restarts exactly as from IDLE.
REQ-022 start while busy SHALL be ignored.
REQ-023 abort=1 in any state SHALL return to IDLE next edge, clear signature/resp_vec/counters, done=0; abort has priority over start in the same cycle.
REQ-024 In IDLE, cut_in SHALL be 4'h0.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, cut_in=0, busy=0, done=0, pass=0, signature=0, resp_vec=0, all counters 0, including mid-run.
REQ-026 After rst_n deasserts, no run SHALL begin without a new start.

Configuration
REQ-027 Macro C9_BIST_RESP_LOG_EN defined: in CAPTURE, resp_vec[pattern counter] <= cut_out; value held through DONE.
REQ-028 Macro undefined: resp_vec port present, tied to 16'h0000, no log flops synthesised; signature behaviour unchanged.

Verification
REQ-029 Fault-free CUT (cut_out = C9 gate model), SETTLE_CYC=2, start pulse -> done after 48 edges, signature=16'h1D0F, pass=1, resp_vec=16'hFFFF (macro on).
REQ-030 cut_out stuck-at-0 -> signature=16'h0000, pass=0, resp_vec=16'h0000 (macro on).
REQ-031 Monitor cut_in during run -> values 0..15 in order, each held exactly SETTLE_CYC+1 cycles; 4'h0 in IDLE/DONE.
REQ-032 start pulsed at pattern 5 -> ignored, run completes unchanged; abort at pattern 7 -> IDLE next edge, busy=0, signature=0.
REQ-033 rst_n pulsed low mid-APPLY (asynchronous to clk) -> outputs clear immediately; new start yields full correct run.
REQ-034 Macro off build, fault-free run -> resp_vec=16'h0000, signature=16'h1D0F, pass=1.

Source files
------------

// File: rtl/c9_bist_ctrl_if.sv
// c9_bist_ctrl_if -- control, status and circuit-under-test signals of the
// exhaustive BIST controller for the 4-input/1-output C9 circuit.
// slave  : view taken by the controller
// master : view taken by whatever drives start/abort and hosts the CUT
interface c9_bist_ctrl_if;
   logic        start;
   logic        abort;
   logic [3:0]  cut_in;
   logic        cut_out;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] signature;
   logic [15:0] resp_vec;

   modport slave (
      input  start, abort, cut_out,
      output cut_in, busy, done, pass, signature, resp_vec
   );

   modport master (
      output start, abort, cut_out,
      input  cut_in, busy, done, pass, signature, resp_vec
   );
endinterface

// File: rtl/c9_bist_ctrl.sv
// c9_bist_ctrl -- exhaustive BIST controller for a 4-input/1-output CUT.
// Applies patterns 0..15 in order, holds each for SETTLE_CYC cycles, then
// captures cut_out into a 16-bit serial signature (poly 16'h1021).
// Optional per-pattern response log enabled by macro C9_BIST_RESP_LOG_EN;
// without it resp_vec reads 16'h0000 and no log flops exist.
module c9_bist_ctrl #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter logic [15:0] GOLDEN_SIG = 16'h1D0F
) (
   input  logic          clk,
   input  logic          rst_n,
   c9_bist_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_APPLY   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // One signature compaction step: shift left, fold in poly when feedback set.
   function automatic logic [15:0] sig_step(input logic [15:0] sig, input logic din);
      logic fb;
      fb = sig[15] ^ din;
      return {sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 32'd1);

   state_t      state_r, state_s;
   logic [3:0]  pat_r, pat_s;
   logic [3:0]  settle_r, settle_s;
   logic [15:0] sig_r, sig_s;
   logic [3:0]  cut_in_r, cut_in_s;
   logic        busy_r, busy_s;
   logic        done_r, done_s;
   logic        pass_r, pass_s;
   logic [15:0] resp_r, resp_s;

   // Next-state, counter, signature and next-output computation.
   always_comb begin
      state_s  = state_r;
      pat_s    = pat_r;
      settle_s = settle_r;
      sig_s    = sig_r;
      resp_s   = resp_r;
      if (bus.abort) begin
         // abort outranks start and clears the whole run context
         state_s  = ST_IDLE;
         pat_s    = 4'h0;
         settle_s = 4'h0;
         sig_s    = 16'h0000;
         resp_s   = 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_s  = ST_APPLY;
                  pat_s    = 4'h0;
                  settle_s = 4'h0;
                  sig_s    = 16'h0000;
                  resp_s   = 16'h0000;
               end else begin
                  state_s = state_r;
               end
            end
            ST_APPLY: begin
               if (settle_r == SETTLE_LAST) begin
                  state_s  = ST_CAPTURE;
                  settle_s = 4'h0;
               end else begin
                  settle_s = settle_r + 4'h1;
               end
            end
            ST_CAPTURE: begin
               sig_s          = sig_step(sig_r, bus.cut_out);
               resp_s[pat_r]  = bus.cut_out;
               if (pat_r == 4'hF) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_APPLY;
                  pat_s   = pat_r + 4'h1;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
      busy_s   = (state_s == ST_APPLY) || (state_s == ST_CAPTURE);
      done_s   = (state_s == ST_DONE);
      pass_s   = done_s && (sig_s == GOLDEN_SIG);
      cut_in_s = busy_s ? pat_s : 4'h0;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Counters, signature and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_r    <= 4'h0;
         settle_r <= 4'h0;
         sig_r    <= 16'h0000;
         cut_in_r <= 4'h0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         pass_r   <= 1'b0;
      end else begin
         pat_r    <= pat_s;
         settle_r <= settle_s;
         sig_r    <= sig_s;
         cut_in_r <= cut_in_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         pass_r   <= pass_s;
      end
   end

`ifdef C9_BIST_RESP_LOG_EN
   // Per-pattern raw response log.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_r <= 16'h0000;
      end else begin
         resp_r <= resp_s;
      end
   end
   assign bus.resp_vec = resp_r;
`else
   // Log disabled: constant zero, next-value logic is left unused.
   assign resp_r       = 16'h0000;
   assign bus.resp_vec = 16'h0000;
`endif

   assign bus.cut_in    = cut_in_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.signature = sig_r;

endmodule
